adex_param_nibble_tx: RTL

Transmitter side of the AdEx neuron's nibble parameter-load protocol. Latches a flat bank of `NUM_PARAMS` parameter bytes on a start request and plays them out as the load-mode / load-strobe / 4-bit-nibble sequence that the neuron's loader consumes. It sits on the host or test side and drives the neuron's `ui_in[4]`, `ui_in[3]` and `uio_in[3:0]`. It provides a start/busy/done handshake and an abort.

---
 rtl/adex_param_nibble_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/adex_param_nibble_tx.sv
// Host-side transmitter for the AdEx nibble parameter-load protocol.
// Snapshots a parameter bank on start and plays it out as load_mode/load_strobe/nibble.
module adex_param_nibble_tx #(
  parameter int NUM_PARAMS = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [8*NUM_PARAMS-1:0] params_flat_i,
  output logic                    load_mode_o,
  output logic                    load_strobe_o,
  output logic [3:0]              nibble_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int NIBS = 2 * NUM_PARAMS;
  localparam int IW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_FINISH
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           nib_idx_q, nib_idx_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic [8*NUM_PARAMS-1:0] shadow_q, shadow_d;
  logic                    load_mode_q, load_mode_d;
  logic                    load_strobe_q, load_strobe_d;
  logic [3:0]              nibble_q, nibble_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Even index selects the high nibble of byte idx/2, odd index the low nibble.
  function automatic logic [3:0] sel_nibble(input logic [8*NUM_PARAMS-1:0] bank,
                                            input logic [IW-1:0] idx);
    int base;
    base = (int'(idx) / 2) * 8 + (idx[0] ? 0 : 4);
    return bank[base +: 4];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      nib_idx_q     <= '0;
      gap_cnt_q     <= '0;
      shadow_q      <= '0;
      load_mode_q   <= 1'b0;
      load_strobe_q <= 1'b0;
      nibble_q      <= 4'h0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nib_idx_q     <= nib_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      shadow_q      <= shadow_d;
      load_mode_q   <= load_mode_d;
      load_strobe_q <= load_strobe_d;
      nibble_q      <= nibble_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nib_idx_d = nib_idx_q;
    gap_cnt_d = gap_cnt_q;
    shadow_d  = shadow_q;
    if (abort_i) begin
      // Abort beats everything, including a start presented in IDLE.
      state_d   = S_IDLE;
      nib_idx_d = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            shadow_d  = params_flat_i;
            nib_idx_d = '0;
            state_d   = S_SETUP;
          end
        end
        S_SETUP:  state_d = S_STROBE;
        S_STROBE: begin
          if (nib_idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            nib_idx_d = nib_idx_q + IW'(1);
            if (GAP_CYCLES > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end else begin
              state_d = S_STROBE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = S_STROBE;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        S_FINISH: begin
          state_d   = S_IDLE;
          nib_idx_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so every port comes straight off a flop.
  always_comb begin
    load_mode_d   = (state_d != S_IDLE);
    busy_d        = (state_d != S_IDLE);
    load_strobe_d = (state_d == S_STROBE);
    done_d        = (state_q == S_FINISH) && !abort_i;
    case (state_d)
      S_IDLE:   nibble_d = 4'h0;
      S_FINISH: nibble_d = nibble_q;
      default:  nibble_d = sel_nibble(shadow_d, nib_idx_d);
    endcase
  end

  assign load_mode_o   = load_mode_q;
  assign load_strobe_o = load_strobe_q;
  assign nibble_o      = nibble_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
